// File: rtl/bcd_display_scan.sv
// Time-multiplexed 4-digit BCD to 7-segment scanner. A frame-boundary snapshot of bcd
// keeps the display free of tearing while the upstream counter moves.
module bcd_display_scan #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] bcd,
    input  logic        freeze,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic        err
);

    localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);

    logic [PreW-1:0] pre_q, pre_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     shadow_q, shadow_d;
    logic            frame_done_q, frame_done_d;
    logic            err_q, err_d;

    logic            tick;
    logic            frame_bd;
    logic            bcd_bad;
    logic [3:0]      nib;
    logic [3:0]      lz;

    assign tick     = (pre_q == PreMax);
    assign frame_bd = tick && (idx_q == 2'd3);

    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    always_comb begin
        pre_d        = tick ? '0 : pre_q + 1'b1;
        idx_d        = tick ? idx_q + 2'd1 : idx_q;
        shadow_d     = shadow_q;
        frame_done_d = frame_bd;
        err_d        = err_q;
        // Frozen boundaries neither capture nor flag invalid input.
        if (frame_bd && !freeze) begin
            shadow_d = bcd;
            err_d    = err_q | bcd_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pre_q        <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= 16'h0000;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    // lz[i]: nibbles i..3 of the snapshot are all zero; digit 0 is never blanked.
    assign lz[0] = 1'b0;
    assign lz[1] = (shadow_q[15:4] == 12'h000);
    assign lz[2] = (shadow_q[15:8] == 8'h00);
    assign lz[3] = (shadow_q[15:12] == 4'h0);

    assign nib = shadow_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        an = 4'b0000;
        an[idx_q] = 1'b1;
    end

    always_comb begin
        seg = 7'h40;
        if (blank_lz && lz[idx_q]) begin
            seg = 7'h00;
        end else begin
            unique case (nib)
                4'd0:    seg = 7'h3F;
                4'd1:    seg = 7'h06;
                4'd2:    seg = 7'h5B;
                4'd3:    seg = 7'h4F;
                4'd4:    seg = 7'h66;
                4'd5:    seg = 7'h6D;
                4'd6:    seg = 7'h7D;
                4'd7:    seg = 7'h07;
                4'd8:    seg = 7'h7F;
                4'd9:    seg = 7'h6F;
                default: seg = 7'h40;
            endcase
        end
    end

    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with SCAN_DIV=4; expected outputs go through a queue.
module tb_bcd_display_scan;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] bcd;
    logic        freeze;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    logic        err;

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bcd_display_scan #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bcd        (bcd),
        .freeze     (freeze),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic expect_out(input string tag, input logic [3:0] a, input logic [6:0] s,
                              input logic fd, input logic e);
        exp_t x;
        x.tag = tag;
        x.v   = {a, s, fd, e};
        sb.push_back(x);
    endtask

    task automatic sample();
        exp_t        x;
        logic [12:0] obs;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed output with no expectation queued");
            return;
        end
        x   = sb.pop_front();
        obs = {an, seg, frame_done, err};
        assert (obs === x.v) else begin
            n_errors++;
            $error("FAIL %s: observed an=%b seg=%h fd=%b err=%b, expected an=%b seg=%h fd=%b err=%b",
                   x.tag, obs[12:9], obs[8:2], obs[1], obs[0],
                   x.v[12:9], x.v[8:2], x.v[1], x.v[0]);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] a, input logic [6:0] s,
                       input logic fd, input logic e);
        expect_out(tag, a, s, fd, e);
        sample();
    endtask

    initial begin
        resetn   = 1'b0;
        bcd      = 16'h1234;
        freeze   = 1'b0;
        blank_lz = 1'b0;
        run(2);
        resetn = 1'b1;
        // cycle 0 after release
        chk("rst_lz0", 4'b0001, 7'h3F, 1'b0, 1'b0);
        blank_lz = 1'b1;
        #1;
        chk("rst_lz1", 4'b0001, 7'h3F, 1'b0, 1'b0);
        blank_lz = 1'b0;
        #1;
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("pre_snap_c%0d", c), 4'(1 << (c / 4)), 7'h3F, 1'b0, 1'b0);
            cyc();
        end
        // cycle 16: first snapshot of 1234
        chk("snap_d0", 4'b0001, 7'h66, 1'b1, 1'b0);
        cyc();
        chk("fd_one_cycle", 4'b0001, 7'h66, 1'b0, 1'b0);
        run(3);
        chk("snap_d1", 4'b0010, 7'h4F, 1'b0, 1'b0);
        run(4);
        chk("snap_d2", 4'b0100, 7'h5B, 1'b0, 1'b0);
        run(4);
        chk("snap_d3", 4'b1000, 7'h06, 1'b0, 1'b0);
        // cycle 28: blanking with 0050
        bcd      = 16'h0050;
        blank_lz = 1'b1;
        #1;
        chk("lz_top_nonzero", 4'b1000, 7'h06, 1'b0, 1'b0);
        run(4);
        chk("lz50_d0", 4'b0001, 7'h3F, 1'b1, 1'b0);
        run(4);
        chk("lz50_d1", 4'b0010, 7'h6D, 1'b0, 1'b0);
        run(4);
        chk("lz50_d2", 4'b0100, 7'h00, 1'b0, 1'b0);
        run(4);
        chk("lz50_d3", 4'b1000, 7'h00, 1'b0, 1'b0);
        bcd = 16'h0000;
        run(4);
        chk("lz0_d0", 4'b0001, 7'h3F, 1'b1, 1'b0);
        run(4);
        chk("lz0_d1", 4'b0010, 7'h00, 1'b0, 1'b0);
        run(4);
        chk("lz0_d2", 4'b0100, 7'h00, 1'b0, 1'b0);
        run(4);
        chk("lz0_d3", 4'b1000, 7'h00, 1'b0, 1'b0);
        // cycle 60: invalid nibble
        bcd      = 16'h9A99;
        blank_lz = 1'b0;
        run(4);
        chk("bad_d0", 4'b0001, 7'h6F, 1'b1, 1'b1);
        run(4);
        chk("bad_d1", 4'b0010, 7'h6F, 1'b0, 1'b1);
        run(4);
        chk("bad_dash", 4'b0100, 7'h40, 1'b0, 1'b1);
        blank_lz = 1'b1;
        #1;
        chk("dash_not_blanked", 4'b0100, 7'h40, 1'b0, 1'b1);
        blank_lz = 1'b0;
        bcd      = 16'h1999;
        run(4);
        chk("bad_d3", 4'b1000, 7'h6F, 1'b0, 1'b1);
        run(4);
        chk("err_sticky", 4'b0001, 7'h6F, 1'b1, 1'b1);
        // cycle 80: freeze
        bcd = 16'h0042;
        run(16);
        chk("pre_freeze", 4'b0001, 7'h5B, 1'b1, 1'b1);
        run(4);
        freeze = 1'b1;
        run(4);
        bcd = 16'h0043;
        run(8);
        chk("freeze_hold_d0", 4'b0001, 7'h5B, 1'b1, 1'b1);
        run(4);
        chk("freeze_hold_d1", 4'b0010, 7'h66, 1'b0, 1'b1);
        freeze = 1'b0;
        run(12);
        chk("unfreeze_load", 4'b0001, 7'h4F, 1'b1, 1'b1);
        run(8);
        // cycle 136: idx=2, err set
        chk("pre_rst_idx2", 4'b0100, 7'h3F, 1'b0, 1'b1);
        resetn = 1'b0;
        cyc();
        chk("mid_rst", 4'b0001, 7'h3F, 1'b0, 1'b0);
        resetn = 1'b1;
        bcd    = 16'h9999;
        // cycle 0 after second release
        run(16);
        chk("tear_9_d0", 4'b0001, 7'h6F, 1'b1, 1'b0);
        run(2);
        bcd = 16'h0000;
        run(2);
        chk("tear_9_d1", 4'b0010, 7'h6F, 1'b0, 1'b0);
        run(4);
        chk("tear_9_d2", 4'b0100, 7'h6F, 1'b0, 1'b0);
        run(4);
        chk("tear_9_d3", 4'b1000, 7'h6F, 1'b0, 1'b0);
        run(4);
        chk("tear_0_d0", 4'b0001, 7'h3F, 1'b1, 1'b0);
        run(4);
        chk("tear_0_d1", 4'b0010, 7'h3F, 1'b0, 1'b0);
        run(4);
        chk("tear_0_d2", 4'b0100, 7'h3F, 1'b0, 1'b0);
        run(4);
        chk("tear_0_d3", 4'b1000, 7'h3F, 1'b0, 1'b0);
        // frozen boundary with invalid input must not set err
        freeze = 1'b1;
        bcd    = 16'hFFFF;
        run(4);
        chk("freeze_no_err", 4'b0001, 7'h3F, 1'b1, 1'b0);
        freeze = 1'b0;
        bcd    = 16'h0000;
        run(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clock cycles each digit is displayed; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port bcd, input, 16: four packed BCD digits, [3:0]=ones, [15:12]=thousands; driven from the upstream 4-digit decimal counter.
REQ-005 SHALL have port freeze, input, 1: when high, the frame-boundary snapshot is skipped.
REQ-006 SHALL have port blank_lz, input, 1: leading-zero blanking enable.
REQ-007 SHALL have port seg, output, 7: segments {g,f,e,d,c,b,a}, active-high.
REQ-008 SHALL have port an, output, 4: digit enable, one-hot, active-high; an[i] selects digit i.
REQ-009 SHALL have port frame_done, output, 1: one-cycle pulse at each frame boundary.
REQ-010 SHALL have port err, output, 1: sticky flag for a non-BCD nibble captured into the snapshot.

Function
REQ-011 SHALL keep prescaler pre counting 0..SCAN_DIV-1 and wrapping; tick = (pre == SCAN_DIV-1); with SCAN_DIV=1, tick is high every cycle.
REQ-012 SHALL keep 2-bit digit index idx; on tick idx increments modulo 4 (0->1->2->3->0); idx holds otherwise.
REQ-013 SHALL define the frame boundary as tick && idx==3.
REQ-014 SHALL, at a frame boundary with freeze=0, load 16-bit shadow register from bcd.
REQ-015 SHALL, at a frame boundary with freeze=1, leave shadow unchanged.
REQ-016 SHALL register frame_done high for exactly the cycle after each frame boundary, independent of freeze.
REQ-017 SHALL drive an = one-hot(idx) and seg from idx and shadow only; no combinational path from bcd, freeze or pre to seg/an; blank_lz is the only input that may feed seg combinationally.
REQ-018 SHALL decode nibble shadow[4*idx+3:4*idx] to seg: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-019 SHALL display nibble values 10..15 as dash, seg=40.
REQ-020 SHALL, when blank_lz=1, force seg=00 for digit i (i=1..3) when shadow nibbles i..3 are all zero; digit 0 is never blanked; an stays one-hot while blanked.
REQ-021 SHALL apply blanking before the dash rule (a non-zero invalid nibble is never blanked).
REQ-022 SHALL set err on any snapshot load in which any nibble of bcd exceeds 9; err stays high until reset, and skipped snapshots (freeze=1) never set it.
REQ-023 SHALL keep shadow coherent: bcd changes between frame boundaries (including upstream 9999->0000 rollover) never alter seg within a frame.

Reset
REQ-024 SHALL, on any clock edge with resetn=0, set pre=0, idx=0, shadow=0000, frame_done=0 and err=0, taking priority over tick, freeze and snapshot.
REQ-025 SHALL present seg=3F and an=0001 from the first cycle after reset, for both blank_lz values.
REQ-026 SHALL produce the first post-reset frame boundary at cycle 4*SCAN_DIV-1 after release.

Verification
REQ-027 SHALL verify snapshot timing: SCAN_DIV=4, release reset with bcd=1234 -> cycles 0-15 show shadow 0000; frame_done pulses at cycle 16; from cycle 16 an=0001 seg=66, cycle 20 an=0010 seg=4F, cycle 24 an=0100 seg=5B, cycle 28 an=1000 seg=06.
REQ-028 SHALL verify blanking: blank_lz=1, bcd=0050 -> digit3 seg=00, digit2 seg=00, digit1 seg=6D, digit0 seg=3F; bcd=0000 -> only digit0 lit, seg=3F.
REQ-029 SHALL verify invalid input: bcd=9A99 captured -> digit2 seg=40 and err=1; err stays 1 after bcd returns to 1999.
REQ-030 SHALL verify freeze: freeze=1 across a frame boundary while bcd changes 0042->0043 -> seg keeps showing 0042 and frame_done still pulses.
REQ-031 SHALL verify reset mid-frame: resetn=0 for one cycle while idx=2 and err=1 -> next cycle an=0001, seg=3F, err=0, frame_done=0.
REQ-032 SHALL verify no tearing: bcd steps 9999->0000 mid-frame -> all four digits show 9 until the boundary, then all show 0 (blank_lz=0).
